// File: rtl/boxhead_pkg.sv
// Shared types and screen geometry for the enemy movement/attack logic.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package boxhead_pkg;

  typedef enum logic [2:0] {
    ST_DEAD,
    ST_SPAWN,
    ST_CHASE,
    ST_ATTACK,
    ST_COOLDOWN
  } enemy_state_t;

  // Encoding matches the sprite renderer: 0 down, 1 left, 2 up, 3 right.
  typedef enum logic [1:0] {
    DIR_DOWN,
    DIR_LEFT,
    DIR_UP,
    DIR_RIGHT
  } dir_t;

  localparam int ENEMY_SIZE = 26;
  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 240;

  function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/enemy_axis_step.sv
// One-axis chase step: moves cur toward target by min(step, |target-cur|), clamped to [0,max].
// Latency: purely combinational.
// Backpressure: none.
// Ports: cur/target/step/max (9b in); next (stepped position), abs_diff (|target-cur|),
//        positive (1 when target is above cur, i.e. the step goes in the + direction).
module enemy_axis_step
  import boxhead_pkg::*;
(
  input  logic [8:0] cur,
  input  logic [8:0] target,
  input  logic [8:0] step,
  input  logic [8:0] max,
  output logic [8:0] next,
  output logic [8:0] abs_diff,
  output logic       positive
);

  logic [8:0] mag;
  logic [9:0] raw;

  always_comb begin
    positive = (target > cur);
    abs_diff = positive ? (target - cur) : (cur - target);
    mag      = min9(step, abs_diff);
    // One extra bit so the + side cannot wrap before the clamp; the - side
    // saturates at zero instead of underflowing.
    if (positive) begin
      raw = {1'b0, cur} + {1'b0, mag};
    end else if (mag > cur) begin
      raw = 10'd0;
    end else begin
      raw = {1'b0, cur} - {1'b0, mag};
    end
    next = (raw > {1'b0, max}) ? max : raw[8:0];
  end

endmodule

// File: rtl/enemy_controller.sv
// Per-enemy FSM: chases the player on frame ticks, attacks when in range, then cools down.
// Latency: position/direction/attack change is visible 1 Clk after the tick (or Alive change).
// Backpressure: none; acts only on single-cycle frame ticks, Enemy_Alive=0 overrides everything.
// Ports: Clk, Reset (sync, active-high), game_frame_clk_rising_edge (tick), Player_X/Y (9b),
//        Enemy_Alive; outputs Enemy_X/Y (9b, registered), Enemy_Direction (2b, registered),
//        Enemy_Attack_On (decoded from the state register).
module enemy_controller
  import boxhead_pkg::*;
#(
  parameter logic [8:0] SPAWN_X        = 9'd40,
  parameter logic [8:0] SPAWN_Y        = 9'd40,
  parameter logic [8:0] STEP           = 9'd2,
  parameter logic [8:0] ATTACK_RANGE   = 9'd20,
  parameter logic [5:0] COOLDOWN_TICKS = 6'd30,
  parameter logic [8:0] X_MAX          = 9'd294,
  parameter logic [8:0] Y_MAX          = 9'd214
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       game_frame_clk_rising_edge,
  input  logic [8:0] Player_X,
  input  logic [8:0] Player_Y,
  input  logic       Enemy_Alive,
  output logic [8:0] Enemy_X,
  output logic [8:0] Enemy_Y,
  output logic [1:0] Enemy_Direction,
  output logic       Enemy_Attack_On
);

  enemy_state_t state, state_n;
  dir_t         dir_q, dir_n;
  logic [5:0]   cnt, cnt_n;
  logic [8:0]   x_n, y_n;

  logic [8:0] x_step, y_step, dx, dy;
  logic       x_pos, y_pos;
  logic       in_range;

  enemy_axis_step u_step_x (
    .cur      (Enemy_X),
    .target   (Player_X),
    .step     (STEP),
    .max      (X_MAX),
    .next     (x_step),
    .abs_diff (dx),
    .positive (x_pos)
  );

  enemy_axis_step u_step_y (
    .cur      (Enemy_Y),
    .target   (Player_Y),
    .step     (STEP),
    .max      (Y_MAX),
    .next     (y_step),
    .abs_diff (dy),
    .positive (y_pos)
  );

  assign in_range        = (dx <= ATTACK_RANGE) && (dy <= ATTACK_RANGE);
  assign Enemy_Attack_On = (state == ST_ATTACK);
  assign Enemy_Direction = dir_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= ST_DEAD;
      Enemy_X <= SPAWN_X;
      Enemy_Y <= SPAWN_Y;
      dir_q   <= DIR_DOWN;
      cnt     <= 6'd0;
    end else begin
      state   <= state_n;
      Enemy_X <= x_n;
      Enemy_Y <= y_n;
      dir_q   <= dir_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = Enemy_X;
    y_n     = Enemy_Y;
    dir_n   = dir_q;
    cnt_n   = cnt;

    if (!Enemy_Alive) begin
      // Death wins over a coincident tick: no move, no attack transition.
      state_n = ST_DEAD;
      cnt_n   = 6'd0;
    end else begin
      unique case (state)
        ST_DEAD: begin
          state_n = ST_SPAWN;
        end
        ST_SPAWN: begin
          x_n     = SPAWN_X;
          y_n     = SPAWN_Y;
          dir_n   = DIR_DOWN;
          state_n = ST_CHASE;
        end
        ST_CHASE: begin
          if (game_frame_clk_rising_edge) begin
            if (in_range) begin
              state_n = ST_ATTACK;
            end else if (dx >= dy) begin
              // Ties go to X.
              x_n   = x_step;
              dir_n = x_pos ? DIR_RIGHT : DIR_LEFT;
            end else begin
              y_n   = y_step;
              dir_n = y_pos ? DIR_DOWN : DIR_UP;
            end
          end
        end
        ST_ATTACK: begin
          // Attack_On is held across exactly one tick, so gamelogic sees one hit.
          if (game_frame_clk_rising_edge) begin
            state_n = ST_COOLDOWN;
            cnt_n   = COOLDOWN_TICKS;
          end
        end
        ST_COOLDOWN: begin
          if (game_frame_clk_rising_edge) begin
            if (cnt == 6'd0) begin
              state_n = ST_CHASE;
            end else begin
              cnt_n = cnt - 6'd1;
            end
          end
        end
        default: begin
          state_n = ST_DEAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_controller.sv
// Directed bench for enemy_controller: default build plus a corner build
// (spawn 1,1 / range 0 / cooldown 0) for clamping and partial-step cases.
module tb_enemy_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick;
  logic [8:0] px, py;
  logic       alive;
  logic [8:0] ax, ay;
  logic [1:0] adir;
  logic       aatk;

  logic [8:0] bpx, bpy;
  logic       balive;
  logic [8:0] bx, by;
  logic [1:0] bdir;
  logic       batk;

  int tests = 0;
  int fails = 0;
  int damage = 0;
  int atk_seen;

  enemy_controller u_dut (
    .Clk                        (clk),
    .Reset                      (rst),
    .game_frame_clk_rising_edge (tick),
    .Player_X                   (px),
    .Player_Y                   (py),
    .Enemy_Alive                (alive),
    .Enemy_X                    (ax),
    .Enemy_Y                    (ay),
    .Enemy_Direction            (adir),
    .Enemy_Attack_On            (aatk)
  );

  enemy_controller #(
    .SPAWN_X        (9'd1),
    .SPAWN_Y        (9'd1),
    .ATTACK_RANGE   (9'd0),
    .COOLDOWN_TICKS (6'd0)
  ) u_dut_b (
    .Clk                        (clk),
    .Reset                      (rst),
    .game_frame_clk_rising_edge (tick),
    .Player_X                   (bpx),
    .Player_Y                   (bpy),
    .Enemy_Alive                (balive),
    .Enemy_X                    (bx),
    .Enemy_Y                    (by),
    .Enemy_Direction            (bdir),
    .Enemy_Attack_On            (batk)
  );

  // Gamelogic model: one damage event per tick on which Attack_On is high.
  always @(posedge clk) begin
    if (tick && aatk) damage <= damage + 10;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; alive = 1'b0; px = '0; py = '0;
    balive = 1'b0; bpx = '0; bpy = '0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // 1. Reset state, hold while dead.
    check("rst_x", 16'(ax), 16'd40);
    check("rst_y", 16'(ay), 16'd40);
    check("rst_dir", 16'(adir), 16'd0);
    check("rst_atk", 16'(aatk), 16'd0);
    check("rst_b_x", 16'(bx), 16'd1);
    repeat (10) do_tick();
    check("dead_hold_x", 16'(ax), 16'd40);
    check("dead_hold_y", 16'(ay), 16'd40);

    // 2. Spawn then chase along +X.
    px = 9'd200; py = 9'd40; alive = 1'b1;
    idle(2);
    check("spawn_x", 16'(ax), 16'd40);
    check("spawn_dir", 16'(adir), 16'd0);
    repeat (5) do_tick();
    check("chase_x", 16'(ax), 16'd50);
    check("chase_y", 16'(ay), 16'd40);
    check("chase_dir", 16'(adir), 16'd3);
    check("chase_atk", 16'(aatk), 16'd0);

    // 3. Chase along +Y (dy dominates).
    rst = 1'b1; px = 9'd41; py = 9'd100;
    idle(1);
    rst = 1'b0;
    idle(2);
    repeat (10) do_tick();
    check("ychase_x", 16'(ax), 16'd40);
    check("ychase_y", 16'(ay), 16'd60);
    check("ychase_dir", 16'(adir), 16'd0);
    repeat (10) do_tick();
    check("ychase_y2", 16'(ay), 16'd80);
    check("ychase_atk", 16'(aatk), 16'd0);

    // 4. Attack, single damage event, cooldown.
    rst = 1'b1; px = 9'd50; py = 9'd50;
    idle(1);
    rst = 1'b0;
    idle(2);
    do_tick();
    check("atk_on", 16'(aatk), 16'd1);
    check("atk_nomove_x", 16'(ax), 16'd40);
    idle(3);
    check("atk_hold", 16'(aatk), 16'd1);
    check("dmg_before", 16'(damage), 16'd0);
    do_tick();
    check("atk_off", 16'(aatk), 16'd0);
    check("dmg_once", 16'(damage), 16'd10);
    atk_seen = 0;
    repeat (31) begin
      do_tick();
      if (aatk) atk_seen++;
    end
    check("cooldown_no_atk", 16'(atk_seen), 16'd0);
    do_tick();
    check("atk_again", 16'(aatk), 16'd1);
    check("dmg_still", 16'(damage), 16'd10);

    // 5. Death during attack, respawn, death wins over coincident tick.
    @(negedge clk) alive = 1'b0;
    @(negedge clk);
    check("death_atk", 16'(aatk), 16'd0);
    alive = 1'b1;
    idle(2);
    check("respawn_x", 16'(ax), 16'd40);
    check("respawn_y", 16'(ay), 16'd40);
    px = 9'd200; py = 9'd40;
    repeat (3) do_tick();
    check("rechase_x", 16'(ax), 16'd46);
    check("rechase_dir", 16'(adir), 16'd3);
    @(negedge clk) begin alive = 1'b0; tick = 1'b1; end
    @(negedge clk) tick = 1'b0;
    check("death_tick_x", 16'(ax), 16'd46);
    check("death_tick_atk", 16'(aatk), 16'd0);
    repeat (2) do_tick();
    check("dead_hold2_x", 16'(ax), 16'd46);
    alive = 1'b1;
    idle(1);
    check("dead_to_spawn_x", 16'(ax), 16'd46);
    idle(1);
    check("respawn2_x", 16'(ax), 16'd40);
    check("respawn2_dir", 16'(adir), 16'd0);
    check("dmg_final", 16'(damage), 16'd10);

    // 6. Corner build: partial step to 0, no underflow, saturation at max.
    balive = 1'b1; bpx = 9'd0; bpy = 9'd0;
    idle(2);
    check("b_spawn_x", 16'(bx), 16'd1);
    do_tick();
    check("b_partial_x", 16'(bx), 16'd0);
    check("b_partial_y", 16'(by), 16'd1);
    check("b_dir_left", 16'(bdir), 16'd1);
    do_tick();
    check("b_y0", 16'(by), 16'd0);
    check("b_x_noflow", 16'(bx), 16'd0);
    check("b_dir_up", 16'(bdir), 16'd2);
    do_tick();
    check("b_atk", 16'(batk), 16'd1);
    do_tick();
    check("b_cool", 16'(batk), 16'd0);
    do_tick();
    bpx = 9'd319; bpy = 9'd239;
    repeat (300) do_tick();
    check("b_sat_x", 16'(bx), 16'd294);
    check("b_sat_y", 16'(by), 16'd214);
    check("b_sat_dir", 16'(bdir), 16'd3);
    check("b_sat_atk", 16'(batk), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
